esp8266_frame_decoder: RTL

Parametrised decoder for ESP8266 UART payloads of the form `<prefix>:<payload><CR>`, e.g. `+IPD,3:123\r`. It sits between the UART receiver (`rx_int`/`rx_data`) and the application logic. It collects up to `MAX_BYTES` payload bytes after the start character, then commits them atomically when the end character arrives, with a one-cycle valid strobe. It adds length, overflow, restart-on-start and inactivity-timeout behaviour.

---
 rtl/esp8266_frame_decoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/esp8266_frame_decoder.sv
// Decodes ESP8266 UART payloads of the form <prefix>:<payload><CR>.
// Payload bytes that follow START_CHAR are gathered in a shadow buffer and
// handed to the application in one step when END_CHAR arrives.
// Ports:
//   clk, rst         - system clock, asynchronous active-low reset
//   rx_int, rx_data  - UART busy flag (a falling edge marks a byte) and that byte
//   data             - committed payload, first byte in the MSBs
//   data_len         - number of payload bytes in the committed frame
//   frame_valid      - one-cycle pulse when data/data_len/overflow update
//   overflow         - committed frame carried more than MAX_BYTES bytes
//   busy             - a frame is being collected
module esp8266_frame_decoder #(
  parameter int unsigned MAX_BYTES   = 3,
  parameter int unsigned LEN_W       = 2,
  parameter logic [7:0]  START_CHAR  = 8'h3A,
  parameter logic [7:0]  END_CHAR    = 8'h0D,
  parameter logic [7:0]  PAD_CHAR    = 8'h20,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_int,
  input  logic [7:0]             rx_data,
  output logic [8*MAX_BYTES-1:0] data,
  output logic [LEN_W-1:0]       data_len,
  output logic                   frame_valid,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned DATA_W   = 8 * MAX_BYTES;
  // Keep the timer at least one bit wide so the disabled case still elaborates.
  localparam int unsigned TMR_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TMR_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [DATA_W-1:0] PAD_FILL = {MAX_BYTES{PAD_CHAR}};

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_e;

  state_e              state_q, state_d;
  logic                rx_int_d_q, rx_int_d_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    data_len_q, data_len_d;
  logic                frame_valid_q, frame_valid_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
  logic                byte_stb_c;

  // One strobe per falling edge of the UART busy flag.
  assign byte_stb_c = rx_int_d_q & ~rx_int;

  // Next-state, shadow buffer and commit logic.
  always_comb begin
    state_d       = state_q;
    rx_int_d_d    = rx_int;
    shadow_d      = shadow_q;
    count_d       = count_q;
    ovf_d         = ovf_q;
    timer_d       = timer_q;
    data_d        = data_q;
    data_len_d    = data_len_q;
    frame_valid_d = 1'b0;
    overflow_d    = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (byte_stb_c && (rx_data == START_CHAR)) begin
          state_d  = S_COLLECT;
          shadow_d = PAD_FILL;
          count_d  = '0;
          ovf_d    = 1'b0;
          timer_d  = '0;
        end
      end
      S_COLLECT: begin
        if (byte_stb_c) begin
          // A byte always wins over a coincident timeout.
          timer_d = '0;
          if (rx_data == END_CHAR) begin
            data_d        = shadow_q;
            data_len_d    = count_q;
            overflow_d    = ovf_q;
            frame_valid_d = 1'b1;
            state_d       = S_IDLE;
          end else if (rx_data == START_CHAR) begin
            shadow_d = PAD_FILL;
            count_d  = '0;
            ovf_d    = 1'b0;
          end else if (count_q < LEN_W'(MAX_BYTES)) begin
            for (int unsigned k = 0; k < MAX_BYTES; k++) begin
              if (count_q == LEN_W'(k)) begin
                shadow_d[8*(MAX_BYTES-k)-1 -: 8] = rx_data;
              end
            end
            count_d = count_q + LEN_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (TIMEOUT_CYC != 0) begin
          if (timer_q == TMR_W'(TMR_LAST)) begin
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_COLLECT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rx_int_d_q    <= 1'b0;
      shadow_q      <= PAD_FILL;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      timer_q       <= '0;
      data_q        <= PAD_FILL;
      data_len_q    <= '0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_int_d_q    <= rx_int_d_d;
      shadow_q      <= shadow_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      timer_q       <= timer_d;
      data_q        <= data_d;
      data_len_q    <= data_len_d;
      frame_valid_q <= frame_valid_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
    end
  end

  assign data        = data_q;
  assign data_len    = data_len_q;
  assign frame_valid = frame_valid_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;

endmodule
